spi_flash_responder: RTL and testbench
======================================

# spi_flash_responder

Synthesizable SPI mode-0 responder that emulates the subset of a serial NOR flash used by the HACK boot path. It answers READ (0x03), power-down (0xB9) and release-power-down (0xAB) from the HACK SPI controller and serves data bytes from an external byte-wide memory port. It is used for flash-less bring-up boards and as a self-checking loopback target next to the SPI controller.

## Interface
- ADDR_W, 24: width of the MEM_ADDR output; the 24-bit internal address is truncated to ADDR_W LSBs (1..24).
- CLK  in  1  system clock; all logic is sampled on the rising edge.
- RSTX  in  1  asynchronous, active-low reset.
- SPI_SCK  in  1  serial clock from the controller; asynchronous to CLK.
- SPI_CSX  in  1  chip select, active low; asynchronous to CLK.
- SPI_SDO  in  1  controller data out, which the responder samples.
- SPI_SDI  out  1  responder data out to the controller; valid only when SPI_SDI_OE=1.
- SPI_SDI_OE  out  1  output enable for the SPI_SDI pad tristate.
- MEM_ADDR  out  ADDR_W  byte address of the current fetch.
- MEM_RD  out  1  one-cycle read strobe.
- MEM_DATA  in  8  read data; valid on the cycle after MEM_RD.
- SLEEP  out  1  power-down flag.

## Operation
- SCK, CSX and SDO each pass through a 2-FF synchronizer. SCK and CSX edges are detected on the synchronized values.
- Mode 0, MSB first. SDO is sampled on a detected SCK rise. SDI changes on a detected SCK fall.
- States:
  - IDLE: CSX high.
  - CMD: receiving 8 opcode bits.
  - ADDR: receiving 24 address bits, MSB first.
  - DATA: streaming bytes.
  - IGNORE: discard bits until CSX rises.
- Transitions:
  - CSX fall → CMD, bit counter cleared.
  - CSX rise → IDLE from any state.
- After the 8th opcode bit:
  - If SLEEP=0: 0x03 → ADDR. 0xB9 sets SLEEP and goes to IGNORE. 0xAB goes to IGNORE. Any other opcode goes to IGNORE.
  - If SLEEP=1: only 0xAB is honoured; it clears SLEEP and goes to IGNORE. All other opcodes go to IGNORE.
- Byte fetch:
  - On the rise that samples the 24th address bit, pulse MEM_RD with MEM_ADDR = received address.
  - MEM_DATA is loaded into the shift register on the next cycle. Go to DATA.
- DATA:
  - Each detected fall shifts the next bit out, starting with the MSB of the loaded byte.
  - On the rise sampling bit 7 of a byte, increment the address and pulse MEM_RD. The prefetched byte is loaded before the next fall.
  - The 24-bit address wraps from 0xFFFFFF to 0x000000.
- SPI_SDI_OE = 1 only in DATA with CSX low. SPI_SDI = 0 whenever OE = 0.
- If CSX rises mid-byte, the transfer is abandoned and no further MEM_RD is issued.

## Timing
- Reset values:
  - State IDLE, SLEEP=0.
  - SPI_SDI=0, SPI_SDI_OE=0.
  - MEM_RD=0, MEM_ADDR=0.
  - Shift register and counters 0.
- Reset asserted mid-transfer: everything returns to the reset values immediately. The responder stays in IDLE until the next CSX fall after RSTX rises. SLEEP is cleared.
- SCK frequency must be ≤ CLK/8, i.e. each SCK half-period ≥ 4 CLK.
- Edge detect latency is 2 CLK after a pad edge, plus 1 CLK to update SPI_SDI. SDI is therefore stable ≥1 CLK before the next SCK rise.
- MEM_RD is 1 CLK wide. MEM_DATA is sampled exactly 1 CLK later.
- First data MSB appears on SPI_SDI 3 CLK after the SCK fall that follows address bit 24.
- CSX must be high for ≥3 CLK between transactions.
- A CSX edge and an SCK edge detected in the same cycle: the CSX edge wins.

## Structure
- Package spi_flash_pkg holds:
  - opcode constants OP_READ=8'h03, OP_PD=8'hB9, OP_RPD=8'hAB;
  - the state enum.
- Sub-module spi_sync_edge: 2-FF synchronizer with rise/fall pulse outputs, instantiated for SCK and CSX. SDO uses the synchronizer only.
- Top level contains the FSM, bit counter (0..31), 24-bit address register, output shift register, and SLEEP flag.

## Test plan
- Memory at 0x040000 preloaded with "SPI! 123". Send 03 04 00 00, then 64 clocks → SDI bytes 0x53 0x50 0x49 0x21 0x20 0x31 0x32 0x33. MEM_ADDR steps 0x040000..0x040007.
- Send B9, raise CSX, then send 03 04 00 00 → SLEEP=1, SPI_SDI_OE stays 0, no MEM_RD. Then send AB, raise CSX, repeat the read → data returns and SLEEP=0.
- Send 03 FF FF FF and read 2 bytes → MEM_ADDR 0xFFFFFF then 0x000000.
- Send 9F → no MEM_RD, OE=0 for the whole transaction, state returns to IDLE on CSX rise.
- Raise CSX after bit 4 of the second data byte → OE drops within 3 CLK, no further MEM_RD. The next READ works normally.
- Assert RSTX low in mid-DATA → all outputs take reset values immediately. The next full READ after RSTX release returns correct data.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared opcodes and FSM state encoding for the SPI NOR-flash responder.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PD   = 8'hB9;
    localparam logic [7:0] OP_RPD  = 8'hAB;

    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_e;

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pad and byte-wide memory port bundle between the responder and its environment.
interface spi_flash_responder_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              SPI_SCK;
    logic              SPI_CSX;
    logic              SPI_SDO;
    logic              SPI_SDI;
    logic              SPI_SDI_OE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_RD;
    logic [7:0]        MEM_DATA;
    logic              SLEEP;

    modport master (
        output SPI_SCK, SPI_CSX, SPI_SDO, MEM_DATA,
        input  SPI_SDI, SPI_SDI_OE, MEM_ADDR, MEM_RD, SLEEP
    );

    modport slave (
        input  SPI_SCK, SPI_CSX, SPI_SDO, MEM_DATA,
        output SPI_SDI, SPI_SDI_OE, MEM_ADDR, MEM_RD, SLEEP
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad plus single-cycle rise/fall pulses.
module spi_sync_edge (
    input  logic CLK,
    input  logic RSTX,
    input  logic din,
    output logic rise,
    output logic fall
);
    // [1:0] is the synchronizer, [2] holds the previous synchronized level.
    // Resetting low means a CSX still held low when reset releases never looks like a fall.
    logic [2:0] sync_r;

    // Synchronizer and edge history shift chain.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], din};
        end
    end

    assign rise = sync_r[1] & ~sync_r[2];
    assign fall = ~sync_r[1] & sync_r[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating READ / power-down / release-power-down of a serial NOR flash.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W = 24
) (
    input  logic                  CLK,
    input  logic                  RSTX,
    spi_flash_responder_if.slave  bus
);

    logic              sck_rise_s;
    logic              sck_fall_s;
    logic              csx_rise_s;
    logic              csx_fall_s;
    logic [1:0]        sdo_sync_r;
    logic              sdo_s;

    state_e            state_r;
    state_e            state_s;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [CNT_W-1:0]  bit_cnt_s;
    logic [23:0]       addr_r;
    logic [23:0]       addr_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_s;
    logic              sleep_r;
    logic              sleep_s;
    logic              sdi_r;
    logic              sdi_s;
    logic              sdi_bit_s;
    logic              sdi_oe_r;
    logic              sdi_oe_s;
    logic              mem_rd_r;
    logic              mem_rd_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              load_r;
    logic [7:0]        opcode_s;

    spi_sync_edge u_sck_sync (
        .CLK  (CLK),
        .RSTX (RSTX),
        .din  (bus.SPI_SCK),
        .rise (sck_rise_s),
        .fall (sck_fall_s)
    );

    spi_sync_edge u_csx_sync (
        .CLK  (CLK),
        .RSTX (RSTX),
        .din  (bus.SPI_CSX),
        .rise (csx_rise_s),
        .fall (csx_fall_s)
    );

    // Two-flop synchronizer for the controller data line.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            sdo_sync_r <= 2'b00;
        end else begin
            sdo_sync_r <= {sdo_sync_r[0], bus.SPI_SDO};
        end
    end

    assign sdo_s = sdo_sync_r[1];
    // Opcode bits are shifted through the address register; its low byte holds the opcode.
    assign opcode_s = {addr_r[6:0], sdo_s};

    // Next-state and datapath decode; CSX edges take priority over SCK edges.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        addr_s     = addr_r;
        sleep_s    = sleep_r;
        sdi_bit_s  = sdi_r;
        mem_rd_s   = 1'b0;
        mem_addr_s = mem_addr_r;
        if (load_r && (state_r == ST_DATA)) begin
            shift_s = bus.MEM_DATA;
        end else begin
            shift_s = shift_r;
        end

        if (csx_rise_s) begin
            state_s = ST_IDLE;
        end else if (csx_fall_s) begin
            state_s   = ST_CMD;
            bit_cnt_s = 5'd0;
        end else begin
            case (state_r)
                ST_CMD: begin
                    if (sck_rise_s) begin
                        addr_s    = {addr_r[22:0], sdo_s};
                        bit_cnt_s = bit_cnt_r + 5'd1;
                        if (bit_cnt_r == 5'd7) begin
                            state_s = ST_IGNORE;
                            // While asleep only release-power-down has an effect.
                            case (opcode_s)
                                OP_READ: state_s = sleep_r ? ST_IGNORE : ST_ADDR;
                                OP_PD:   sleep_s = 1'b1;
                                OP_RPD:  sleep_s = 1'b0;
                                default: sleep_s = sleep_r;
                            endcase
                        end else begin
                            state_s = ST_CMD;
                        end
                    end else begin
                        state_s = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_s) begin
                        addr_s    = {addr_r[22:0], sdo_s};
                        bit_cnt_s = bit_cnt_r + 5'd1;
                        if (bit_cnt_r == 5'd31) begin
                            state_s    = ST_DATA;
                            mem_rd_s   = 1'b1;
                            mem_addr_s = ADDR_W'(addr_s);
                        end else begin
                            state_s = ST_ADDR;
                        end
                    end else begin
                        state_s = ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (sck_rise_s) begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                        // Last bit of a byte: prefetch the following byte.
                        if (bit_cnt_r[2:0] == 3'd7) begin
                            addr_s     = addr_r + 24'd1;
                            mem_rd_s   = 1'b1;
                            mem_addr_s = ADDR_W'(addr_s);
                        end else begin
                            mem_rd_s = 1'b0;
                        end
                    end else if (sck_fall_s) begin
                        sdi_bit_s = shift_r[7];
                        shift_s   = {shift_r[6:0], 1'b0};
                    end else begin
                        sdi_bit_s = sdi_r;
                    end
                end
                ST_IDLE:   state_s = ST_IDLE;
                ST_IGNORE: state_s = ST_IGNORE;
                default:   state_s = ST_IDLE;
            endcase
        end

        sdi_oe_s = (state_s == ST_DATA);
        sdi_s    = sdi_oe_s & sdi_bit_s;
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 5'd0;
            addr_r     <= 24'd0;
            shift_r    <= 8'd0;
            sleep_r    <= 1'b0;
            sdi_r      <= 1'b0;
            sdi_oe_r   <= 1'b0;
            mem_rd_r   <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            load_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            addr_r     <= addr_s;
            shift_r    <= shift_s;
            sleep_r    <= sleep_s;
            sdi_r      <= sdi_s;
            sdi_oe_r   <= sdi_oe_s;
            mem_rd_r   <= mem_rd_s;
            mem_addr_r <= mem_addr_s;
            load_r     <= mem_rd_r;
        end
    end

    assign bus.SPI_SDI    = sdi_r;
    assign bus.SPI_SDI_OE = sdi_oe_r;
    assign bus.MEM_RD     = mem_rd_r;
    assign bus.MEM_ADDR   = mem_addr_r;
    assign bus.SLEEP      = sleep_r;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized self-checking bench: an SPI controller driver plus a flash behaviour model.
module tb_spi_flash_responder;

    localparam logic [7:0] C_READ  = 8'h03;
    localparam logic [7:0] C_PD    = 8'hB9;
    localparam logic [7:0] C_RPD   = 8'hAB;
    localparam logic [7:0] C_JEDEC = 8'h9F;

    logic clk  = 1'b0;
    logic rstx = 1'b0;
    always #5 clk = ~clk;

    spi_flash_responder_if #(.ADDR_W(24)) bus ();

    spi_flash_responder #(.ADDR_W(24)) dut (
        .CLK  (clk),
        .RSTX (rstx),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_ovr [int unsigned];
    logic [23:0] rd_q [$];
    logic [7:0]  got_q [$];
    int          oe_cnt = 0;
    int          rd_start;
    int          oe_start;
    bit          model_sleep = 1'b0;

    // Memory contents: preloaded overrides, otherwise a fixed hash of the address.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        int unsigned key;
        key = 32'(a);
        if (mem_ovr.exists(key)) return mem_ovr[key];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // External memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.MEM_RD === 1'b1) bus.MEM_DATA <= mem_byte(bus.MEM_ADDR);
    end

    // Monitor of read strobes and output-enable activity.
    always @(negedge clk) begin
        if (bus.MEM_RD === 1'b1) rd_q.push_back(bus.MEM_ADDR);
        if (bus.SPI_SDI_OE === 1'b1) oe_cnt <= oe_cnt + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of tx out MSB first, capturing SDI just before each SCK rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.SPI_SDO = tx[7-i];
            wait_clks(5);
            rx[7-i] = bus.SPI_SDI;
            bus.SPI_SCK = 1'b1;
            wait_clks(5);
            bus.SPI_SCK = 1'b0;
        end
    endtask

    task automatic cs_low();
        rd_start = rd_q.size();
        oe_start = oe_cnt;
        got_q.delete();
        bus.SPI_CSX = 1'b0;
        wait_clks(4);
    endtask

    task automatic cs_high();
        wait_clks(2);
        bus.SPI_CSX = 1'b1;
        wait_clks(8);
    endtask

    // One command followed by optional address and n dummy/data bytes.
    task automatic spi_cmd(input logic [7:0] op, input bit with_addr, input logic [23:0] a, input int n);
        logic [7:0] rx;
        cs_low();
        spi_bits(op, 8, rx);
        if (with_addr) begin
            spi_bits(a[23:16], 8, rx);
            spi_bits(a[15:8], 8, rx);
            spi_bits(a[7:0], 8, rx);
        end
        for (int k = 0; k < n; k++) begin
            spi_bits(8'h00, 8, rx);
            got_q.push_back(rx);
        end
        cs_high();
    endtask

    task automatic test_reset();
        bus.SPI_CSX = 1'b1;
        bus.SPI_SCK = 1'b0;
        bus.SPI_SDO = 1'b0;
        rstx = 1'b0;
        wait_clks(4);
        checks++; if (bus.SPI_SDI !== 1'b0)    begin errors++; $display("FAIL reset_sdi: got %b expected 0", bus.SPI_SDI); end
        checks++; if (bus.SPI_SDI_OE !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", bus.SPI_SDI_OE); end
        checks++; if (bus.MEM_RD !== 1'b0)     begin errors++; $display("FAIL reset_rd: got %b expected 0", bus.MEM_RD); end
        checks++; if (bus.MEM_ADDR !== 24'h0)  begin errors++; $display("FAIL reset_addr: got %h expected 000000", bus.MEM_ADDR); end
        checks++; if (bus.SLEEP !== 1'b0)      begin errors++; $display("FAIL reset_sleep: got %b expected 0", bus.SLEEP); end
        rstx = 1'b1;
        wait_clks(6);
        checks++; if (bus.SPI_SDI_OE !== 1'b0) begin errors++; $display("FAIL post_reset_oe: got %b expected 0", bus.SPI_SDI_OE); end
    endtask

    task automatic test_read_basic();
        logic [7:0] txt [8] = '{8'h53, 8'h50, 8'h49, 8'h21, 8'h20, 8'h31, 8'h32, 8'h33};
        for (int k = 0; k < 8; k++) mem_ovr[32'h0004_0000 + k] = txt[k];
        spi_cmd(C_READ, 1'b1, 24'h040000, 8);
        for (int k = 0; k < 8; k++) begin
            checks++; if (got_q[k] !== txt[k]) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", k, got_q[k], txt[k]); end
        end
        checks++;
        if (rd_q.size() - rd_start !== 9) begin
            errors++; $display("FAIL basic_rd_count: got %0d expected 9", rd_q.size() - rd_start);
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (rd_q[rd_start+k] !== 24'h040000 + 24'(k)) begin
                    errors++; $display("FAIL basic_rd_addr[%0d]: got %h expected %h", k, rd_q[rd_start+k], 24'h040000 + 24'(k));
                end
            end
        end
    endtask

    task automatic test_random_reads();
        for (int t = 0; t < 5; t++) begin
            logic [23:0] a;
            int          n;
            a = 24'($urandom);
            n = $urandom_range(1, 4);
            spi_cmd(C_READ, 1'b1, a, n);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (got_q[k] !== mem_byte(a + 24'(k))) begin
                    errors++; $display("FAIL rand_data[%0d/%0d]: got %h expected %h", t, k, got_q[k], mem_byte(a + 24'(k)));
                end
            end
            checks++;
            if (rd_q.size() - rd_start !== n + 1) begin
                errors++; $display("FAIL rand_rd_count[%0d]: got %0d expected %0d", t, rd_q.size() - rd_start, n + 1);
            end else begin
                for (int k = 0; k <= n; k++) begin
                    checks++;
                    if (rd_q[rd_start+k] !== a + 24'(k)) begin
                        errors++; $display("FAIL rand_rd_addr[%0d/%0d]: got %h expected %h", t, k, rd_q[rd_start+k], a + 24'(k));
                    end
                end
            end
        end
    endtask

    task automatic test_power_down();
        spi_cmd(C_PD, 1'b0, 24'h0, 0);
        model_sleep = 1'b1;
        checks++; if (bus.SLEEP !== model_sleep) begin errors++; $display("FAIL pd_sleep: got %b expected %b", bus.SLEEP, model_sleep); end
        spi_cmd(C_READ, 1'b1, 24'h040000, 2);
        checks++; if (rd_q.size() - rd_start !== 0) begin errors++; $display("FAIL pd_rd_count: got %0d expected 0", rd_q.size() - rd_start); end
        checks++; if (oe_cnt - oe_start !== 0)      begin errors++; $display("FAIL pd_oe_cycles: got %0d expected 0", oe_cnt - oe_start); end
        checks++; if (got_q[0] !== 8'h00)           begin errors++; $display("FAIL pd_sdi: got %h expected 00", got_q[0]); end
        spi_cmd(C_RPD, 1'b0, 24'h0, 0);
        model_sleep = 1'b0;
        checks++; if (bus.SLEEP !== model_sleep) begin errors++; $display("FAIL rpd_sleep: got %b expected %b", bus.SLEEP, model_sleep); end
        spi_cmd(C_READ, 1'b1, 24'h040000, 2);
        checks++; if (got_q[0] !== 8'h53) begin errors++; $display("FAIL rpd_data0: got %h expected 53", got_q[0]); end
        checks++; if (got_q[1] !== 8'h50) begin errors++; $display("FAIL rpd_data1: got %h expected 50", got_q[1]); end
    endtask

    task automatic test_wrap();
        spi_cmd(C_READ, 1'b1, 24'hFFFFFF, 2);
        checks++; if (got_q[0] !== mem_byte(24'hFFFFFF)) begin errors++; $display("FAIL wrap_data0: got %h expected %h", got_q[0], mem_byte(24'hFFFFFF)); end
        checks++; if (got_q[1] !== mem_byte(24'h000000)) begin errors++; $display("FAIL wrap_data1: got %h expected %h", got_q[1], mem_byte(24'h000000)); end
        checks++;
        if (rd_q.size() - rd_start < 2) begin
            errors++; $display("FAIL wrap_rd_count: got %0d expected 3", rd_q.size() - rd_start);
        end else begin
            checks++; if (rd_q[rd_start] !== 24'hFFFFFF)   begin errors++; $display("FAIL wrap_addr0: got %h expected ffffff", rd_q[rd_start]); end
            checks++; if (rd_q[rd_start+1] !== 24'h000000) begin errors++; $display("FAIL wrap_addr1: got %h expected 000000", rd_q[rd_start+1]); end
        end
    endtask

    task automatic test_unknown_op();
        spi_cmd(C_JEDEC, 1'b1, 24'h123456, 2);
        checks++; if (rd_q.size() - rd_start !== 0) begin errors++; $display("FAIL unk_rd_count: got %0d expected 0", rd_q.size() - rd_start); end
        checks++; if (oe_cnt - oe_start !== 0)      begin errors++; $display("FAIL unk_oe_cycles: got %0d expected 0", oe_cnt - oe_start); end
        spi_cmd(C_RPD, 1'b0, 24'h0, 0);
        checks++; if (bus.SLEEP !== 1'b0) begin errors++; $display("FAIL awake_rpd_sleep: got %b expected 0", bus.SLEEP); end
        spi_cmd(C_READ, 1'b1, 24'h040003, 1);
        checks++; if (got_q[0] !== 8'h21) begin errors++; $display("FAIL unk_after_read: got %h expected 21", got_q[0]); end
    endtask

    task automatic test_abort();
        logic [7:0]  rx;
        logic [23:0] a;
        a = 24'($urandom);
        cs_low();
        spi_bits(C_READ, 8, rx);
        spi_bits(a[23:16], 8, rx);
        spi_bits(a[15:8], 8, rx);
        spi_bits(a[7:0], 8, rx);
        spi_bits(8'h00, 8, rx);
        checks++; if (rx !== mem_byte(a)) begin errors++; $display("FAIL abort_byte0: got %h expected %h", rx, mem_byte(a)); end
        spi_bits(8'h00, 4, rx);
        checks++; if (rx[7:4] !== mem_byte(a + 24'd1) >> 4) begin errors++; $display("FAIL abort_nibble: got %h expected %h", rx[7:4], mem_byte(a + 24'd1) >> 4); end
        checks++; if (bus.SPI_SDI_OE !== 1'b1) begin errors++; $display("FAIL abort_oe_before: got %b expected 1", bus.SPI_SDI_OE); end
        bus.SPI_CSX = 1'b1;
        wait_clks(3);
        checks++; if (bus.SPI_SDI_OE !== 1'b0) begin errors++; $display("FAIL abort_oe_drop: got %b expected 0", bus.SPI_SDI_OE); end
        checks++; if (bus.SPI_SDI !== 1'b0)    begin errors++; $display("FAIL abort_sdi: got %b expected 0", bus.SPI_SDI); end
        wait_clks(10);
        checks++; if (rd_q.size() - rd_start !== 2) begin errors++; $display("FAIL abort_rd_count: got %0d expected 2", rd_q.size() - rd_start); end
        spi_cmd(C_READ, 1'b1, 24'h040004, 2);
        checks++; if (got_q[0] !== 8'h20) begin errors++; $display("FAIL abort_next0: got %h expected 20", got_q[0]); end
        checks++; if (got_q[1] !== 8'h31) begin errors++; $display("FAIL abort_next1: got %h expected 31", got_q[1]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        spi_cmd(C_PD, 1'b0, 24'h0, 0);
        rstx = 1'b0;
        #1;
        checks++; if (bus.SLEEP !== 1'b0) begin errors++; $display("FAIL rst_sleep_clear: got %b expected 0", bus.SLEEP); end
        model_sleep = 1'b0;
        wait_clks(2);
        rstx = 1'b1;
        wait_clks(4);
        cs_low();
        spi_bits(C_READ, 8, rx);
        spi_bits(8'h12, 8, rx);
        spi_bits(8'h34, 8, rx);
        spi_bits(8'h56, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 3, rx);
        rstx = 1'b0;
        #1;
        checks++; if (bus.SPI_SDI !== 1'b0)    begin errors++; $display("FAIL rst_mid_sdi: got %b expected 0", bus.SPI_SDI); end
        checks++; if (bus.SPI_SDI_OE !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b expected 0", bus.SPI_SDI_OE); end
        checks++; if (bus.MEM_RD !== 1'b0)     begin errors++; $display("FAIL rst_mid_rd: got %b expected 0", bus.MEM_RD); end
        checks++; if (bus.MEM_ADDR !== 24'h0)  begin errors++; $display("FAIL rst_mid_addr: got %h expected 000000", bus.MEM_ADDR); end
        wait_clks(3);
        rstx = 1'b1;
        wait_clks(2);
        rd_start = rd_q.size();
        oe_start = oe_cnt;
        for (int k = 0; k < 2; k++) spi_bits(8'h00, 8, rx);
        cs_high();
        checks++; if (rd_q.size() - rd_start !== 0) begin errors++; $display("FAIL rst_idle_rd: got %0d expected 0", rd_q.size() - rd_start); end
        checks++; if (oe_cnt - oe_start !== 0)      begin errors++; $display("FAIL rst_idle_oe: got %0d expected 0", oe_cnt - oe_start); end
        spi_cmd(C_READ, 1'b1, 24'h040000, 8);
        for (int k = 0; k < 8; k++) begin
            checks++; if (got_q[k] !== mem_byte(24'h040000 + 24'(k))) begin errors++; $display("FAIL rst_after_data[%0d]: got %h expected %h", k, got_q[k], mem_byte(24'h040000 + 24'(k))); end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_random_reads();
        test_power_down();
        test_wrap();
        test_unknown_op();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
